// File: rtl/robo_pkg.sv
// Shared types and constants for the wall-following robot controller.
package robo_pkg;

  typedef enum logic [2:0] {
    SEARCH,
    FOLLOW,
    TURN_ADV,
    ROTATE,
    REMOVE,
    DONE,
    TRAPPED
  } state_t;

  typedef enum logic [1:0] {
    NONE,
    AVANCAR,
    GIRAR,
    REMOVER
  } action_t;

  // A right turn is one left turn plus this many more
  localparam int RIGHT_TURN_EXTRA = 2;

endpackage

// File: rtl/robo_sat_counter.sv
// Saturating up-counter with increment enable; sticks at all-ones.
module robo_sat_counter #(
  parameter int MOVE_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              inc,
  output logic [MOVE_W-1:0] count
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/robo_seguidor_param.sv
// Left-hand wall-following controller with timed barrier removal,
// trap detection, lap counting and a saturating move counter.
module robo_seguidor_param
  import robo_pkg::*;
#(
  parameter int REMOVE_CYCLES = 2,
  parameter int TRAP_TURNS    = 8,
  parameter int LAPS          = 1,
  parameter int MOVE_W        = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              head,
  input  logic              left,
  input  logic              under,
  input  logic              barrier,
  output logic              avancar,
  output logic              girar,
  output logic              remover,
  output logic              done,
  output logic              trapped,
  output logic [MOVE_W-1:0] moves
);

  localparam int TURN_W = $clog2(TRAP_TURNS + 1);
  localparam int LAP_W  = $clog2(LAPS + 1);
  localparam int REM_W  = $clog2(REMOVE_CYCLES + 1);
  localparam int PEND_W = $clog2(RIGHT_TURN_EXTRA + 1);

  localparam logic [TURN_W-1:0] TRAP_LIMIT = TURN_W'(TRAP_TURNS);
  localparam logic [LAP_W-1:0]  LAP_LAST   = LAP_W'(LAPS - 1);
  localparam logic [REM_W-1:0]  REM_LIMIT  = REM_W'(REMOVE_CYCLES);
  localparam logic [PEND_W-1:0] PEND_FULL  = PEND_W'(RIGHT_TURN_EXTRA);
  localparam logic [PEND_W-1:0] PEND_ONE   = PEND_W'(1);

  state_t            state, state_n;
  action_t           act, act_n;
  logic [TURN_W-1:0] turn_cnt, turn_n;
  logic [LAP_W-1:0]  lap_cnt, lap_n;
  logic [REM_W-1:0]  rem_cnt, rem_n;
  logic [PEND_W-1:0] pend_cnt, pend_n;
  logic              arrival;
  logic              move_inc;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= SEARCH;
      act      <= NONE;
      turn_cnt <= '0;
      lap_cnt  <= '0;
      rem_cnt  <= '0;
      pend_cnt <= '0;
    end else begin
      state    <= state_n;
      act      <= act_n;
      turn_cnt <= turn_n;
      lap_cnt  <= lap_n;
      rem_cnt  <= rem_n;
      pend_cnt <= pend_n;
    end
  end

  // Trap beats lap completion, which beats the normal wall-following decision
  always_comb begin
    state_n = state;
    act_n   = NONE;
    turn_n  = turn_cnt;
    lap_n   = lap_cnt;
    rem_n   = rem_cnt;
    pend_n  = pend_cnt;
    arrival = (act == AVANCAR) && under;

    if (state == DONE || state == TRAPPED) begin
      state_n = state;
    end else if (turn_cnt >= TRAP_LIMIT) begin
      state_n = TRAPPED;
      pend_n  = '0;
    end else if (arrival && (lap_cnt == LAP_LAST)) begin
      state_n = DONE;
      lap_n   = lap_cnt + 1'b1;
    end else begin
      if (arrival) begin
        lap_n = lap_cnt + 1'b1;
      end
      case (state)
        ROTATE: begin
          act_n  = GIRAR;
          pend_n = pend_cnt - 1'b1;
          if (pend_cnt == PEND_ONE) begin
            state_n = FOLLOW;
          end
        end
        REMOVE: begin
          if (rem_cnt < REM_LIMIT) begin
            act_n = REMOVER;
            rem_n = rem_cnt + 1'b1;
          end else begin
            rem_n   = '0;
            state_n = FOLLOW;
          end
        end
        default: begin
          // SEARCH only keeps searching while the left side is still open
          if (state == FOLLOW && !left) begin
            act_n   = GIRAR;
            state_n = TURN_ADV;
          end else if (!head) begin
            act_n   = AVANCAR;
            state_n = (state == SEARCH && !left) ? SEARCH : FOLLOW;
          end else if (barrier) begin
            act_n   = REMOVER;
            rem_n   = REM_W'(1);
            state_n = REMOVE;
          end else begin
            act_n   = GIRAR;
            pend_n  = PEND_FULL;
            state_n = ROTATE;
          end
        end
      endcase
      if (act_n == GIRAR) begin
        turn_n = turn_cnt + 1'b1;
      end else if (act_n == AVANCAR) begin
        turn_n = '0;
      end
    end
  end

  always_comb begin
    avancar = (act == AVANCAR);
    girar   = (act == GIRAR);
    remover = (act == REMOVER);
    done    = (state == DONE);
    trapped = (state == TRAPPED);
  end

  assign move_inc = (act_n == AVANCAR);

  robo_sat_counter #(
    .MOVE_W(MOVE_W)
  ) u_moves (
    .clock(clock),
    .reset(reset),
    .inc  (move_inc),
    .count(moves)
  );

endmodule

// File: tb/tb_robo_seguidor_param.sv
// Self-checking bench: directed vector table, hand-built corner sequences and
// randomized sensors compared against an action-plan reference model.
module tb_robo_seguidor_param;

  localparam int REMOVE_CYCLES = 3;
  localparam int TRAP_TURNS    = 8;
  localparam int LAPS          = 2;
  localparam int MOVE_W        = 8;
  localparam int SAT_W         = 4;
  localparam int MV_MAX        = (1 << MOVE_W) - 1;
  localparam int SAT_MAX       = (1 << SAT_W) - 1;

  localparam int A_NONE = 0;
  localparam int A_AV   = 1;
  localparam int A_GI   = 2;
  localparam int A_RM   = 3;

  typedef struct {
    logic [3:0] sens;  // {head, left, under, barrier}
    logic [3:0] outs;  // {avancar, girar, remover, done}
    int         mv;
  } vec_t;

  logic clock   = 1'b0;
  logic reset   = 1'b0;
  logic head    = 1'b0;
  logic left    = 1'b0;
  logic under   = 1'b1;
  logic barrier = 1'b0;

  logic              avancar, girar, remover, done, trapped;
  logic [MOVE_W-1:0] moves;
  logic              s_avancar, s_girar, s_remover, s_done, s_trapped;
  logic [SAT_W-1:0]  s_moves;

  int checks   = 0;
  int failures = 0;

  // Reference model: mode 0 = searching, 1 = following, 2 = just turned left
  int   m_mode, m_act, m_turns, m_laps, m_moves;
  bit   m_done, m_trapped;
  int   plan[$];

  vec_t tbl[$];
  int   gcount, first_trap, pos, first_done, done_moves, hold;
  logic rh, rl, ru, rb;

  always #5 clock = ~clock;

  robo_seguidor_param #(
    .REMOVE_CYCLES(REMOVE_CYCLES),
    .TRAP_TURNS   (TRAP_TURNS),
    .LAPS         (LAPS),
    .MOVE_W       (MOVE_W)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .head   (head),
    .left   (left),
    .under  (under),
    .barrier(barrier),
    .avancar(avancar),
    .girar  (girar),
    .remover(remover),
    .done   (done),
    .trapped(trapped),
    .moves  (moves)
  );

  robo_seguidor_param #(
    .REMOVE_CYCLES(REMOVE_CYCLES),
    .TRAP_TURNS   (TRAP_TURNS),
    .LAPS         (LAPS),
    .MOVE_W       (SAT_W)
  ) dut_sat (
    .clock  (clock),
    .reset  (reset),
    .head   (head),
    .left   (left),
    .under  (under),
    .barrier(barrier),
    .avancar(s_avancar),
    .girar  (s_girar),
    .remover(s_remover),
    .done   (s_done),
    .trapped(s_trapped),
    .moves  (s_moves)
  );

  task automatic modelReset();
    m_mode    = 0;
    m_act     = A_NONE;
    m_turns   = 0;
    m_laps    = 0;
    m_moves   = 0;
    m_done    = 1'b0;
    m_trapped = 1'b0;
    plan.delete();
  endtask

  // Multi-cycle behaviours are queued as a plan of future actions
  task automatic modelEdge(input logic h, input logic l, input logic u, input logic b);
    bit arrived;
    arrived = (m_act == A_AV) && u;
    if (m_done || m_trapped) begin
      m_act = A_NONE;
    end else if (m_turns >= TRAP_TURNS) begin
      m_trapped = 1'b1;
      m_act     = A_NONE;
      plan.delete();
    end else if (arrived && (m_laps + 1 == LAPS)) begin
      m_laps = m_laps + 1;
      m_done = 1'b1;
      m_act  = A_NONE;
    end else begin
      if (arrived) m_laps = m_laps + 1;
      if (plan.size() > 0) begin
        m_act = plan.pop_front();
      end else if (m_mode == 1 && !l) begin
        m_act  = A_GI;
        m_mode = 2;
      end else if (!h) begin
        m_act = A_AV;
        if (!(m_mode == 0 && !l)) m_mode = 1;
      end else if (b) begin
        m_act = A_RM;
        repeat (REMOVE_CYCLES - 1) plan.push_back(A_RM);
        plan.push_back(A_NONE);
        m_mode = 1;
      end else begin
        m_act = A_GI;
        plan.push_back(A_GI);
        plan.push_back(A_GI);
        m_mode = 1;
      end
      if (m_act == A_GI) m_turns = m_turns + 1;
      else if (m_act == A_AV) m_turns = 0;
      if (m_act == A_AV) m_moves = m_moves + 1;
    end
  endtask

  task automatic applyStimulus(input logic h, input logic l, input logic u, input logic b);
    head    = h;
    left    = l;
    under   = u;
    barrier = b;
    @(posedge clock);
    modelEdge(h, l, u, b);
    @(negedge clock);
  endtask

  task automatic checkOutput(input string name);
    logic [4:0] got, exp;
    int         exp_mv, exp_sv;
    got    = {avancar, girar, remover, done, trapped};
    exp    = {m_act == A_AV, m_act == A_GI, m_act == A_RM, m_done, m_trapped};
    exp_mv = (m_moves > MV_MAX) ? MV_MAX : m_moves;
    exp_sv = (m_moves > SAT_MAX) ? SAT_MAX : m_moves;
    checks++;
    if (got !== exp || moves !== MOVE_W'(exp_mv)) begin
      failures++;
      $display("[TB] FAIL %s: got av/gi/rm/done/trap=%b moves=%0d, expected %b moves=%0d",
               name, got, moves, exp, exp_mv);
    end
    checks++;
    if (s_moves !== SAT_W'(exp_sv)) begin
      failures++;
      $display("[TB] FAIL %s_sat: got moves=%0d, expected %0d", name, s_moves, exp_sv);
    end
  endtask

  task automatic checkConst(input string name, input logic [4:0] exp, input int mv);
    logic [4:0] got;
    int         exp_sv;
    got    = {avancar, girar, remover, done, trapped};
    exp_sv = (mv > SAT_MAX) ? SAT_MAX : mv;
    checks++;
    if (got !== exp || moves !== MOVE_W'(mv) || s_moves !== SAT_W'(exp_sv)) begin
      failures++;
      $display("[TB] FAIL %s: got av/gi/rm/done/trap=%b moves=%0d sat=%0d, expected %b moves=%0d sat=%0d",
               name, got, moves, s_moves, exp, mv, exp_sv);
    end
  endtask

  task automatic doReset();
    reset   = 1'b0;
    head    = 1'b0;
    left    = 1'b0;
    under   = 1'b1;
    barrier = 1'b0;
    modelReset();
    @(negedge clock);
    @(negedge clock);
    checkConst("reset_state", 5'b00000, 0);
    reset = 1'b1;
  endtask

  task automatic addVec(input logic [3:0] sens, input logic [3:0] outs, input int mv);
    vec_t v;
    v.sens = sens;
    v.outs = outs;
    v.mv   = mv;
    tbl.push_back(v);
  endtask

  initial begin
    modelReset();

    // sensors {h,l,u,b}            actions {av,gi,rm,done}
    addVec(4'b0010, 4'b1000, 1);  // search, open ahead; start cell not an arrival
    addVec(4'b0100, 4'b1000, 2);  // wall found on the left
    addVec(4'b1100, 4'b0100, 2);  // blocked: right turn, 3 girar
    addVec(4'b0000, 4'b0100, 2);
    addVec(4'b0000, 4'b0100, 2);
    addVec(4'b1101, 4'b0010, 2);  // barrier: remover x3, then idle
    addVec(4'b0000, 4'b0010, 2);
    addVec(4'b0000, 4'b0010, 2);
    addVec(4'b0000, 4'b0000, 2);
    addVec(4'b0100, 4'b1000, 3);
    addVec(4'b1000, 4'b0100, 3);  // left opens: turn left
    addVec(4'b0100, 4'b1000, 4);  // then advance
    addVec(4'b1000, 4'b0100, 4);
    addVec(4'b1001, 4'b0010, 4);  // barrier right after a left turn
    addVec(4'b1010, 4'b0010, 4);
    addVec(4'b1010, 4'b0010, 4);
    addVec(4'b1010, 4'b0000, 4);
    addVec(4'b1010, 4'b0100, 4);  // under without a prior advance: no arrival
    addVec(4'b1100, 4'b0100, 4);
    addVec(4'b0000, 4'b0100, 4);
    addVec(4'b0000, 4'b0100, 4);
    addVec(4'b0110, 4'b1000, 5);
    addVec(4'b0110, 4'b1000, 6);  // arrival 1
    addVec(4'b0110, 4'b0001, 6);  // arrival 2: done
    addVec(4'b0100, 4'b0001, 6);

    doReset();
    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i].sens[3], tbl[i].sens[2], tbl[i].sens[1], tbl[i].sens[0]);
      checkConst($sformatf("vec%0d", i), {tbl[i].outs, 1'b0}, tbl[i].mv);
    end

    // Walled on all sides
    doReset();
    gcount     = 0;
    first_trap = 0;
    for (int c = 1; c <= 14; c++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput($sformatf("trap_cyc%0d", c));
      if (girar) gcount++;
      if (trapped && first_trap == 0) first_trap = c;
    end
    checks++;
    if (gcount != TRAP_TURNS) begin
      failures++;
      $display("[TB] FAIL trap_girar_count: got %0d, expected %0d", gcount, TRAP_TURNS);
    end
    checks++;
    if (first_trap != TRAP_TURNS + 1) begin
      failures++;
      $display("[TB] FAIL trap_rise_cycle: got %0d, expected %0d", first_trap, TRAP_TURNS + 1);
    end

    // 20-cell loop, two laps
    doReset();
    pos        = 0;
    first_done = 0;
    done_moves = 0;
    for (int c = 1; c <= 50; c++) begin
      applyStimulus(1'b0, 1'b1, pos == 0, 1'b0);
      checkOutput($sformatf("loop_cyc%0d", c));
      if (avancar) pos = (pos + 1) % 20;
      if (done && first_done == 0) begin
        first_done = c;
        done_moves = int'(moves);
      end
    end
    checks++;
    if (first_done != 41 || done_moves != 40) begin
      failures++;
      $display("[TB] FAIL loop_done: got cycle=%0d moves=%0d, expected cycle=41 moves=40",
               first_done, done_moves);
    end
    checkConst("loop_hold", 5'b00010, 40);

    // Asynchronous reset in the middle of a removal
    doReset();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkConst("rm_pre_adv", 5'b10000, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    checkConst("rm_enter", 5'b00100, 1);
    #2 reset = 1'b0;
    modelReset();
    #1;
    checkConst("rm_async_reset", 5'b00000, 0);
    @(negedge clock);
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkConst("rm_after_release", 5'b10000, 1);

    // Randomized sensors against the model
    doReset();
    hold = 0;
    for (int c = 0; c < 800; c++) begin
      if (m_done || m_trapped) begin
        hold++;
        if (hold > 3) begin
          doReset();
          hold = 0;
        end
      end
      rh = ($urandom_range(0, 1) == 1);
      rl = ($urandom_range(0, 3) != 0);
      ru = ($urandom_range(0, 7) == 0);
      rb = ($urandom_range(0, 2) == 0);
      applyStimulus(rh, rl, ru, rb);
      checkOutput($sformatf("rand%0d", c));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
